i3c_bus_owner_arb: RTL and testbench

I3C_BUS_OWNER_ARB -- requirements
Module: i3c_bus_owner_arb

---
 rtl/i3c_arb_pkg.sv | 31 +++
 rtl/i3c_rr_pick.sv | 35 +++
 rtl/i3c_bus_owner_arb.sv | 156 +++++++++++++++
 tb/tb_i3c_bus_owner_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_arb_pkg.sv
// Shared definitions for the I3C bus-owner arbiter: FSM state codes,
// released-bus drive levels and helpers that size counters and indices.
package i3c_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_FREE_WAIT = 2'd0;
    localparam logic [1:0] ST_OWNED     = 2'd1;
    localparam logic [1:0] ST_REVOKE    = 2'd2;

    // Pad drive levels when nobody owns the bus (released, open-drain)
    localparam logic REL_SCL   = 1'b1;
    localparam logic REL_SDA   = 1'b1;
    localparam logic REL_OD_PP = 1'b0;

    // Bits needed to hold a count from 0 up to max_val inclusive
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    // Bits needed to index n requesters (never less than one)
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/i3c_rr_pick.sv
// Round-robin picker: scans the request vector starting just after the
// last granted index and returns a one-hot vector for the first hit.
module i3c_rr_pick
    import i3c_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]              req_vec,
    input  logic [idx_width(NUM_REQ)-1:0]   last_idx,
    output logic [NUM_REQ-1:0]              pick
);

    localparam int IW = idx_width(NUM_REQ);

    logic          found;
    logic [IW-1:0] idx;
    int            pos;

    // Walk NUM_REQ positions from last_idx+1 (wrapping) and keep the first requester seen
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = (int'(last_idx) + i) % NUM_REQ;
            idx = IW'(pos);
            if (!found && req_vec[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i3c_bus_owner_arb.sv
// I3C bus-owner arbiter: waits for a run of bus-free cycles, grants one
// requester round-robin, muxes that owner's drive onto the pads, and
// forcibly revokes ownership held longer than HOLD_TIMEOUT cycles.
module i3c_bus_owner_arb
    import i3c_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUS_FREE_CYC = 8,
    parameter int HOLD_TIMEOUT = 4096
) (
    input  logic               core_clk,
    input  logic               rst_l,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    input  logic [NUM_REQ-1:0] req_scl_i,
    input  logic [NUM_REQ-1:0] req_sda_i,
    input  logic [NUM_REQ-1:0] req_od_pp_i,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               scl_o,
    output logic               sda_o,
    output logic               sel_od_pp_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int FW = cnt_width(BUS_FREE_CYC);
    localparam int HW = cnt_width(HOLD_TIMEOUT);
    localparam int IW = idx_width(NUM_REQ);

    localparam logic [FW-1:0] FREE_FULL = FW'(BUS_FREE_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 0) ? (HOLD_TIMEOUT - 1) : 0);
    localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [FW-1:0]      free_cnt;
    logic [HW-1:0]      hold_cnt;
    logic [NUM_REQ-1:0] inelig;
    logic [IW-1:0]      last_gnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_idx;
    logic               owner_req;
    logic               bus_free;
    logic               hold_expired;
    logic               grant_now;
    logic               revoke_now;

    assign eligible     = req_i & ~inelig;
    assign owner_req    = |(gnt_q & req_i);
    assign bus_free     = (free_cnt == FREE_FULL);
    assign hold_expired = (HOLD_TIMEOUT != 0) && (hold_cnt == HOLD_LAST);
    assign grant_now    = (state == ST_FREE_WAIT) && (state_nxt == ST_OWNED);
    assign revoke_now   = (state == ST_OWNED) && (state_nxt == ST_REVOKE);

    i3c_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_vec  (eligible),
        .last_idx (last_gnt),
        .pick     (pick)
    );

    // Convert the one-hot pick into an index for the round-robin pointer
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    // Next-state logic; an owner dropping its request wins over a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FREE_WAIT: begin
                if (bus_free && (|eligible)) begin
                    state_nxt = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    state_nxt = ST_FREE_WAIT;
                end else if (hold_expired) begin
                    state_nxt = ST_REVOKE;
                end
            end
            ST_REVOKE: begin
                state_nxt = ST_FREE_WAIT;
            end
            default: begin
                state_nxt = ST_FREE_WAIT;
            end
        endcase
    end

    // State, counters, grant register and the revoked-requester mask
    always_ff @(posedge core_clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= ST_FREE_WAIT;
            free_cnt <= '0;
            hold_cnt <= '0;
            inelig   <= '0;
            last_gnt <= LAST_RST;
            gnt_q    <= '0;
        end else begin
            state <= state_nxt;

            if ((state != ST_FREE_WAIT) || (state_nxt != ST_FREE_WAIT) || !(scl_i && sda_i)) begin
                free_cnt <= '0;
            end else if (free_cnt != FREE_FULL) begin
                free_cnt <= free_cnt + 1'b1;
            end

            if (grant_now) begin
                hold_cnt <= '0;
            end else if (state == ST_OWNED) begin
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end

            inelig <= (inelig & req_i) | (revoke_now ? gnt_q : '0);

            if (grant_now) begin
                gnt_q    <= pick;
                last_gnt <= pick_idx;
            end else if (state_nxt != ST_OWNED) begin
                gnt_q <= '0;
            end
        end
    end

    // Pad drive: follow the owner while granted, otherwise release the bus
    always_comb begin
        scl_o       = REL_SCL;
        sda_o       = REL_SDA;
        sel_od_pp_o = REL_OD_PP;
        if (|gnt_q) begin
            scl_o       = |(gnt_q & req_scl_i);
            sda_o       = |(gnt_q & req_sda_i);
            sel_od_pp_o = |(gnt_q & req_od_pp_i);
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = |gnt_q;
    assign timeout_o = (state == ST_REVOKE);

endmodule

// File: tb/tb_i3c_bus_owner_arb.sv
// Directed self-checking bench for i3c_bus_owner_arb with two requesters,
// an 8-cycle bus-free window and a 16-cycle hold timeout.
module tb_i3c_bus_owner_arb;

    logic       core_clk;
    logic       rst_l;
    logic [1:0] req_i;
    logic [1:0] gnt_o;
    logic [1:0] req_scl_i;
    logic [1:0] req_sda_i;
    logic [1:0] req_od_pp_i;
    logic       scl_i;
    logic       sda_i;
    logic       scl_o;
    logic       sda_o;
    logic       sel_od_pp_o;
    logic       busy_o;
    logic       timeout_o;

    int checks;
    int failures;

    i3c_bus_owner_arb #(
        .NUM_REQ      (2),
        .BUS_FREE_CYC (8),
        .HOLD_TIMEOUT (16)
    ) dut (
        .core_clk    (core_clk),
        .rst_l       (rst_l),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .req_scl_i   (req_scl_i),
        .req_sda_i   (req_sda_i),
        .req_od_pp_i (req_od_pp_i),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_o       (scl_o),
        .sda_o       (sda_o),
        .sel_od_pp_o (sel_od_pp_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    // Free-running clock, 10 time units per period
    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_released(input string tag);
        check_output({tag, "_scl"}, 32'(scl_o), 32'd1);
        check_output({tag, "_sda"}, 32'(sda_o), 32'd1);
        check_output({tag, "_od"},  32'(sel_od_pp_o), 32'd0);
    endtask

    // Directed scenario sequence
    initial begin
        checks      = 0;
        failures    = 0;
        rst_l       = 1'b0;
        req_i       = 2'b00;
        req_scl_i   = 2'b00;
        req_sda_i   = 2'b00;
        req_od_pp_i = 2'b11;
        scl_i       = 1'b1;
        sda_i       = 1'b1;

        // Reset values
        #1;
        check_output("rst_gnt", 32'(gnt_o), 32'd0);
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_timeout", 32'(timeout_o), 32'd0);
        check_released("rst");

        // First grant after 8 free cycles plus one
        tick();
        rst_l       = 1'b1;
        req_i       = 2'b01;
        req_od_pp_i = 2'b00;
        ticks(8);
        check_output("first_gnt_early", 32'(gnt_o), 32'd0);
        tick();
        check_output("first_gnt", 32'(gnt_o), 32'd1);
        check_output("first_busy", 32'(busy_o), 32'd1);

        // Owner drive follows requester 0 combinationally
        req_scl_i = 2'b01;
        #1 check_output("follow_scl_hi", 32'(scl_o), 32'd1);
        req_scl_i = 2'b10;
        #1 check_output("follow_scl_lo", 32'(scl_o), 32'd0);
        req_sda_i = 2'b00;
        #1 check_output("follow_sda_lo", 32'(sda_o), 32'd0);
        req_sda_i = 2'b01;
        #1 check_output("follow_sda_hi", 32'(sda_o), 32'd1);
        req_od_pp_i = 2'b01;
        #1 check_output("follow_od", 32'(sel_od_pp_o), 32'd1);
        req_od_pp_i = 2'b00;

        // Requester 1 arrives while 0 owns: no preemption
        req_i = 2'b11;
        ticks(4);
        check_output("no_preempt", 32'(gnt_o), 32'd1);
        req_i = 2'b10;
        tick();
        check_output("rel0_gnt", 32'(gnt_o), 32'd0);
        check_output("rel0_busy", 32'(busy_o), 32'd0);
        req_i = 2'b11;
        ticks(8);
        check_output("gap0_gnt", 32'(gnt_o), 32'd0);
        tick();
        check_output("rr_gnt1", 32'(gnt_o), 32'd2);

        // Requester 1 releases, round-robin returns to 0
        ticks(4);
        check_output("own1_hold", 32'(gnt_o), 32'd2);
        req_i = 2'b01;
        tick();
        check_output("rel1_gnt", 32'(gnt_o), 32'd0);
        ticks(8);
        check_output("gap1_gnt", 32'(gnt_o), 32'd0);
        tick();
        check_output("rr_gnt0", 32'(gnt_o), 32'd1);

        // sda low at free_cnt=6 restarts the bus-free count
        req_i = 2'b00;
        tick();
        req_i = 2'b01;
        ticks(6);
        sda_i = 1'b0;
        tick();
        sda_i = 1'b1;
        ticks(8);
        check_output("restart_early", 32'(gnt_o), 32'd0);
        tick();
        check_output("restart_gnt", 32'(gnt_o), 32'd1);

        // Hold timeout: requester 0 keeps its request for too long
        req_i       = 2'b11;
        req_scl_i   = 2'b00;
        req_sda_i   = 2'b00;
        req_od_pp_i = 2'b11;
        ticks(15);
        check_output("pre_revoke_gnt", 32'(gnt_o), 32'd1);
        check_output("pre_revoke_to", 32'(timeout_o), 32'd0);
        check_output("pre_revoke_scl", 32'(scl_o), 32'd0);
        tick();
        check_output("revoke_gnt", 32'(gnt_o), 32'd0);
        check_output("revoke_to", 32'(timeout_o), 32'd1);
        check_released("revoke");
        tick();
        check_output("post_revoke_to", 32'(timeout_o), 32'd0);
        ticks(8);
        check_output("post_revoke_early", 32'(gnt_o), 32'd0);
        tick();
        check_output("revoke_next_gnt", 32'(gnt_o), 32'd2);

        // Revoked requester 0 stays ineligible until it toggles req_i
        req_od_pp_i = 2'b00;
        ticks(3);
        req_i = 2'b01;
        tick();
        check_output("inelig_rel_gnt", 32'(gnt_o), 32'd0);
        ticks(12);
        check_output("inelig_gnt", 32'(gnt_o), 32'd0);
        check_output("inelig_busy", 32'(busy_o), 32'd0);
        req_i = 2'b00;
        tick();
        req_i = 2'b01;
        tick();
        check_output("retoggle_gnt", 32'(gnt_o), 32'd1);

        // Request drop coincident with timeout is a normal release
        ticks(15);
        check_output("coinc_own", 32'(gnt_o), 32'd1);
        req_i = 2'b00;
        tick();
        check_output("coinc_gnt", 32'(gnt_o), 32'd0);
        check_output("coinc_to", 32'(timeout_o), 32'd0);
        req_i = 2'b01;
        tick();
        check_output("coinc_to_next", 32'(timeout_o), 32'd0);
        ticks(7);
        check_output("coinc_early", 32'(gnt_o), 32'd0);
        tick();
        check_output("coinc_regnt", 32'(gnt_o), 32'd1);

        // Asynchronous reset mid-ownership releases the bus at once
        req_od_pp_i = 2'b11;
        req_scl_i   = 2'b00;
        req_sda_i   = 2'b00;
        #1 check_output("pre_rst_od", 32'(sel_od_pp_o), 32'd1);
        rst_l = 1'b0;
        #1;
        check_output("async_rst_gnt", 32'(gnt_o), 32'd0);
        check_output("async_rst_busy", 32'(busy_o), 32'd0);
        check_released("async_rst");
        #1 rst_l = 1'b1;
        ticks(8);
        check_output("restart_rst_early", 32'(gnt_o), 32'd0);
        tick();
        check_output("restart_rst_gnt", 32'(gnt_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
